// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receiver for 8N1 frames: 8 data bits, no parity, 1 stop bit, LSB
//   first, line idle high. The asynchronous rx pin is brought into the clock
//   domain through a two-flop synchroniser. A start bit is qualified at its
//   centre, and each data bit and the stop bit are then sampled once per bit
//   period. Good bytes land in a one-entry holding register with a
//   valid/ack handshake.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per bit period (must be >= 4)
//
// Ports
//   clk        system clock; all logic on the rising edge
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   rx_ack     consumer pulse; clears rx_valid
//   data_out   last good byte; stable while rx_valid is high
//   rx_valid   high from byte delivery until acknowledged
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a byte overwrites an unacked one
//   busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int          HALF     = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_END = 16'(HALF - 1);
  localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] clk_cnt;
  logic [15:0] clk_cnt_nxt;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_nxt;
  logic [7:0]  shift;
  logic [7:0]  shift_nxt;
  logic        deliver;
  logic        stop_bad;

  logic        rx_meta;
  logic        rx_s;

  // ---- Stage: input synchroniser (rx -> rx_meta -> rx_s) ----
  // Both flops reset to the idle level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // ---- Stage: FSM state and bit-timing registers ----
  // The shift register is fully rewritten by eight samples before any
  // delivery, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  // Next-state logic. Every bit sample happens at the end of a full bit
  // period measured from the start-bit centre, so samples land mid-bit.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    deliver     = 1'b0;
    stop_bad    = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
        end
      end

      START: begin
        clk_cnt_nxt = clk_cnt + 16'd1;
        if (clk_cnt == HALF_END) begin
          if (!rx_s) begin
            state_nxt   = DATA;
            clk_cnt_nxt = '0;
            bit_idx_nxt = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            state_nxt = IDLE;
          end
        end
      end

      DATA: begin
        clk_cnt_nxt = clk_cnt + 16'd1;
        if (clk_cnt == BIT_END) begin
          // LSB arrives first; right-shifting leaves it in bit 0 at the end.
          shift_nxt   = {rx_s, shift[7:1]};
          clk_cnt_nxt = '0;
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end

      STOP: begin
        clk_cnt_nxt = clk_cnt + 16'd1;
        if (clk_cnt == BIT_END) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            // Leaving at mid-stop lets a back-to-back start edge be caught.
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        // Hold here through a break so a stuck-low line is not read as
        // a stream of 0x00 bytes.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- Stage: registered outputs and holding register ----
  // An ack arriving in the delivery cycle is taken as consuming the old
  // byte, so the new byte stays valid and no overrun is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= deliver && rx_valid && !rx_ack;
      busy      <= (state_nxt != IDLE);
      if (deliver) begin
        data_out <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx with CLKS_PER_BIT = 16 (HALF = 8). Frames are
//   driven one bit period at a time on falling edges while a watcher samples
//   the outputs on falling edges, logging busy, pulses and deliveries.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_ack;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_errs   = 0;

  // Watcher results
  int         fe_cnt;
  int         ov_cnt;
  int         rise_at;
  int         valid_seen;
  logic       busy_log [0:400];
  logic [7:0] got [$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One 8N1 frame, each bit held for CPB cycles; rx is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  // Samples n falling edges. Index i is the i-th falling edge after the call.
  // auto_ack acks every valid byte one cycle after it is seen; ack_at >= 0
  // raises rx_ack for the cycle following falling edge ack_at.
  task automatic watch(input int n, input bit auto_ack, input int ack_at);
    fe_cnt     = 0;
    ov_cnt     = 0;
    rise_at    = -1;
    valid_seen = 0;
    got.delete();
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid) valid_seen = 1;
      if (rx_valid && rise_at < 0) rise_at = i;
      busy_log[i] = busy;
      if (rx_ack) begin
        rx_ack = 1'b0;
      end else if (auto_ack && rx_valid) begin
        got.push_back(data_out);
        rx_ack = 1'b1;
      end
      if (i == ack_at) rx_ack = 1'b1;
    end
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int busy_late;

    rst    = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single 0xA5 frame: E0 is the 3rd edge after rx falls (2-flop sync),
    // rx_valid appears after E0 + HALF + 9*CPB = edge 155.
    fork
      send_frame(8'hA5, 1'b1);
      watch(170, 1'b0, -1);
    join
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_valid_rise", 32'(rise_at), 32'd155);
    chk("a5_busy_before_e0", 32'(busy_log[2]), 32'h0);
    chk("a5_busy_after_e0", 32'(busy_log[3]), 32'h1);
    chk("a5_busy_before_stop", 32'(busy_log[154]), 32'h1);
    chk("a5_busy_after_stop", 32'(busy_log[155]), 32'h0);
    chk("a5_frame_err", 32'(fe_cnt), 32'd0);
    ack_once();
    chk("a5_ack_clears", 32'(rx_valid), 32'h0);

    // Back-to-back 0x00, 0xFF with exactly one stop bit, acked promptly.
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      watch(330, 1'b1, -1);
    join
    chk("b2b_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("b2b_first", 32'(got[0]), 32'h00);
      chk("b2b_second", 32'(got[1]), 32'hFF);
    end
    chk("b2b_overrun", 32'(ov_cnt), 32'd0);
    chk("b2b_frame_err", 32'(fe_cnt), 32'd0);
    repeat (4) @(negedge clk);

    // 0x3C with low stop bit, then line held low 40 more cycles.
    // Line returns high after edge 200; FSM sees rx_s=1 at edge 203.
    fork
      begin
        send_frame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        rx = 1'b1;
      end
      watch(230, 1'b0, -1);
    join
    chk("ferr_pulses", 32'(fe_cnt), 32'd1);
    chk("ferr_no_valid", 32'(valid_seen), 32'd0);
    chk("ferr_busy_break", 32'(busy_log[180]), 32'h1);
    chk("ferr_busy_hold", 32'(busy_log[202]), 32'h1);
    chk("ferr_busy_exit", 32'(busy_log[203]), 32'h0);
    repeat (4) @(negedge clk);

    // 5-cycle low glitch: START check at edge 11 sees the line high again.
    fork
      begin
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
      end
      watch(40, 1'b0, -1);
    join
    busy_late = 0;
    for (int i = 11; i <= 40; i++) begin
      if (busy_log[i]) busy_late++;
    end
    chk("glitch_busy_start", 32'(busy_log[10]), 32'h1);
    chk("glitch_busy_late", 32'(busy_late), 32'd0);
    chk("glitch_no_valid", 32'(valid_seen), 32'd0);
    chk("glitch_frame_err", 32'(fe_cnt), 32'd0);

    // Overrun: 0x11 left unacked, then 0x22 arrives.
    fork
      send_frame(8'h11, 1'b1);
      watch(170, 1'b0, -1);
    join
    chk("ovr_first_data", 32'(data_out), 32'h11);
    chk("ovr_first_none", 32'(ov_cnt), 32'd0);
    fork
      send_frame(8'h22, 1'b1);
      watch(170, 1'b0, -1);
    join
    chk("ovr_pulses", 32'(ov_cnt), 32'd1);
    chk("ovr_data", 32'(data_out), 32'h22);
    chk("ovr_valid", 32'(rx_valid), 32'h1);

    // 0x22 still unacked; ack lands exactly on the delivery edge (155) of 0x44.
    fork
      send_frame(8'h44, 1'b1);
      watch(170, 1'b0, 154);
    join
    chk("ackdel_overrun", 32'(ov_cnt), 32'd0);
    chk("ackdel_valid", 32'(rx_valid), 32'h1);
    chk("ackdel_data", 32'(data_out), 32'h44);

    // Reset in the middle of data bit 4 (0xC3, bit 4 = 0), with 0x44 pending.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rx = (k < 2) ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_data_out", 32'(data_out), 32'h00);
    chk("midrst_rx_valid", 32'(rx_valid), 32'h0);
    chk("midrst_frame_err", 32'(frame_err), 32'h0);
    chk("midrst_overrun", 32'(overrun), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    rx  = 1'b1;
    fork
      begin
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b1);
      end
      watch(200, 1'b1, -1);
    join
    chk("post_rst_count", 32'(got.size()), 32'd1);
    if (got.size() == 1) chk("post_rst_data", 32'(got[0]), 32'h5A);
    chk("post_rst_frame_err", 32'(fe_cnt), 32'd0);
    chk("post_rst_overrun", 32'(ov_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
